// File: rtl/trig_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : trig_window_gen
// Purpose  : Turns trigger edges into fixed-length DAT_FIFO write windows,
//            each followed by a holdoff. Triggers are refused when the FIFO
//            cannot hold a whole window. Accepted and dropped triggers are
//            counted.
// Options  : TWG_TIMESTAMP_EN - when defined, builds a 32-bit free-running
//            timestamp and latches it on every accepted trigger. Otherwise
//            o_ts_latch is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module trig_window_gen #(
  parameter int WIN_LEN    = 256,
  parameter int HOLDOFF    = 16,
  parameter int FIFO_DEPTH = 1024,
  parameter int EVT_W      = 16,
  localparam int FIFO_AW   = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_run_en,
  input  logic               i_trig_in,
  input  logic [FIFO_AW-1:0] i_fifo_wrusedw,
  input  logic               i_fifo_full,
  output logic               o_fifo_wrreq,
  output logic               o_busy,
  output logic               o_win_last,
  output logic               o_truncated,
  output logic [EVT_W-1:0]   o_evt_cnt,
  output logic [EVT_W-1:0]   o_drop_cnt,
  output logic [31:0]        o_ts_latch
);

  // Window and holdoff counter widths; a single-cycle window/holdoff still
  // needs a one-bit counter so the code stays uniform.
  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [CW-1:0]      c_WIN_INIT  = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0]      c_CNT_ONE   = CW'(1);
  localparam logic [HW-1:0]      c_HOLD_INIT = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [HW-1:0]      c_HOLD_ONE  = HW'(1);
  localparam logic [EVT_W-1:0]   c_EVT_ONE   = EVT_W'(1);
  localparam logic [FIFO_AW:0]   c_DEPTH     = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   c_WIN_WORDS = (FIFO_AW+1)'(WIN_LEN);
  localparam logic               c_LAST_ON_ACCEPT = (WIN_LEN == 1);
  localparam logic               c_NO_HOLD        = (HOLDOFF == 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_trig_d;
  logic [CW-1:0]     r_cnt;
  logic [HW-1:0]     r_hcnt;
  logic              r_wrreq;
  logic              r_win_last;
  logic              r_busy;
  logic              r_truncated;
  logic [EVT_W-1:0]  r_evt_cnt;
  logic [EVT_W-1:0]  r_drop_cnt;

  logic              w_edge;
  logic [FIFO_AW:0]  w_free;
  logic              w_room;
  logic              w_accept;
  logic              w_drop;

  // Free space is computed one bit wider than the fill level so a full
  // depth of FIFO_DEPTH words never wraps.
  assign w_edge   = i_trig_in & ~r_trig_d;
  assign w_free   = c_DEPTH - {1'b0, i_fifo_wrusedw};
  assign w_room   = (w_free >= c_WIN_WORDS);
  assign w_accept = (r_state == S_IDLE) & w_edge & i_run_en & w_room & ~i_fifo_full;
  // Edges while not idle are always dropped; idle edges only count as drops
  // when readout is enabled but the FIFO cannot take a full window.
  assign w_drop   = w_edge & ((r_state != S_IDLE) |
                              (i_run_en & ~(w_room & ~i_fifo_full)));

  // Window FSM: acceptance, capture countdown, holdoff and event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_trig_d    <= 1'b0;
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_wrreq     <= 1'b0;
      r_win_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_truncated <= 1'b0;
      r_evt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_trig_d <= i_trig_in;

      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + c_EVT_ONE;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_CAPTURE;
            r_cnt      <= c_WIN_INIT;
            r_wrreq    <= 1'b1;
            r_win_last <= c_LAST_ON_ACCEPT;
            r_busy     <= 1'b1;
            r_evt_cnt  <= r_evt_cnt + c_EVT_ONE;
          end
        end

        S_CAPTURE: begin
          if (i_fifo_full || (r_cnt == '0)) begin
            // Window ends either normally or cut short by a full FIFO.
            r_wrreq    <= 1'b0;
            r_win_last <= 1'b0;
            if (i_fifo_full) begin
              r_truncated <= 1'b1;
            end
            if (c_NO_HOLD) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_HOLD;
              r_hcnt  <= c_HOLD_INIT;
            end
          end else begin
            r_cnt      <= r_cnt - c_CNT_ONE;
            r_win_last <= (r_cnt == c_CNT_ONE);
          end
        end

        S_HOLD: begin
          if (r_hcnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hcnt <= r_hcnt - c_HOLD_ONE;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_wrreq    <= 1'b0;
          r_win_last <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // A full FIFO gates the registered strobe in the same cycle, so a cut
  // window never issues a write or a last marker into a full FIFO.
  assign o_fifo_wrreq = r_wrreq & ~i_fifo_full;
  assign o_win_last   = r_win_last & ~i_fifo_full;
  assign o_busy       = r_busy;
  assign o_truncated  = r_truncated;
  assign o_evt_cnt    = r_evt_cnt;
  assign o_drop_cnt   = r_drop_cnt;

`ifdef TWG_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_ts_latch;

  // Free-running timestamp, captured on each accepted trigger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts       <= '0;
      r_ts_latch <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_accept) begin
        r_ts_latch <= r_ts;
      end
    end
  end

  assign o_ts_latch = r_ts_latch;
`else
  assign o_ts_latch = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trig_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_window_gen
// Purpose  : Directed, table-driven check of trig_window_gen with
//            WIN_LEN=8, HOLDOFF=4, FIFO_DEPTH=16, plus hand-written sequences
//            for the bounded window wait and the timestamp latch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trig_window_gen;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic        trig_in;
  logic [3:0]  wrusedw;
  logic        fifo_full;
  logic        wrreq;
  logic        busy;
  logic        win_last;
  logic        truncated;
  logic [15:0] evt_cnt;
  logic [15:0] drop_cnt;
  logic [31:0] ts_latch;

  int total;
  int bad;

  trig_window_gen #(
    .WIN_LEN    (8),
    .HOLDOFF    (4),
    .FIFO_DEPTH (16),
    .EVT_W      (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_run_en       (run_en),
    .i_trig_in      (trig_in),
    .i_fifo_wrusedw (wrusedw),
    .i_fifo_full    (fifo_full),
    .o_fifo_wrreq   (wrreq),
    .o_busy         (busy),
    .o_win_last     (win_last),
    .o_truncated    (truncated),
    .o_evt_cnt      (evt_cnt),
    .o_drop_cnt     (drop_cnt),
    .o_ts_latch     (ts_latch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: zeroed by reset, counts every clock.
  logic [31:0] tb_ts;
  always @(posedge clk) begin
    if (!rst_n) tb_ts <= 32'd0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  typedef struct {
    int          n;
    logic        rst_n;
    logic        run;
    logic        trig;
    logic [3:0]  used;
    logic        full;
    logic        wr;
    logic        bsy;
    logic        last;
    logic        trunc;
    logic [15:0] evt;
    logic [15:0] drop;
    logic        acc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int n, input logic r, input logic run, input logic trig,
                     input int used, input logic full, input logic wr, input logic bsy,
                     input logic last, input logic trunc, input int evt, input int drop,
                     input logic acc);
    vec_t v;
    v.n = n; v.rst_n = r; v.run = run; v.trig = trig; v.used = 4'(used);
    v.full = full; v.wr = wr; v.bsy = bsy; v.last = last; v.trunc = trunc;
    v.evt = 16'(evt); v.drop = 16'(drop); v.acc = acc;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, want);
    end
  endtask

  function automatic logic [31:0] ts_want(input logic [31:0] v);
`ifdef TWG_TIMESTAMP_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; run_en = 1'b0; trig_in = 1'b0; wrusedw = 4'd0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrreq", 32'(wrreq), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_last",  32'(win_last), 32'd0);
    chk("rst_trunc", 32'(truncated), 32'd0);
    chk("rst_evt",   32'(evt_cnt), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    chk("rst_ts",    ts_latch, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_ts;
    logic [31:0] snap;
    int          nwr;
    logic        seen;

    total = 0;
    bad   = 0;

    // n, rst_n, run, trig, used, full | wr, busy, last, trunc, evt, drop | acc
    // Basic window: pulse in cycle 10, writes 11..18, last at 18, busy to 22.
    add(10,1,1,0,0,0, 0,0,0,0, 0,0, 0);
    add( 1,1,1,1,0,0, 0,0,0,0, 0,0, 1);
    add( 7,1,1,0,0,0, 1,1,0,0, 1,0, 0);
    add( 1,1,1,0,0,0, 1,1,1,0, 1,0, 0);
    add( 4,1,1,0,0,0, 0,1,0,0, 1,0, 0);
    add( 5,1,1,0,0,0, 0,0,0,0, 1,0, 0);
    // Trigger held high 100 cycles: one window, no drops.
    add( 1,1,1,1,0,0, 0,0,0,0, 1,0, 1);
    add( 7,1,1,1,0,0, 1,1,0,0, 2,0, 0);
    add( 1,1,1,1,0,0, 1,1,1,0, 2,0, 0);
    add( 4,1,1,1,0,0, 0,1,0,0, 2,0, 0);
    add(87,1,1,1,0,0, 0,0,0,0, 2,0, 0);
    add( 3,1,1,0,0,0, 0,0,0,0, 2,0, 0);
    // Extra edges in CAPTURE and HOLD are dropped.
    add( 1,1,1,1,0,0, 0,0,0,0, 2,0, 1);
    add( 3,1,1,0,0,0, 1,1,0,0, 3,0, 0);
    add( 1,1,1,1,0,0, 1,1,0,0, 3,0, 0);
    add( 3,1,1,0,0,0, 1,1,0,0, 3,1, 0);
    add( 1,1,1,0,0,0, 1,1,1,0, 3,1, 0);
    add( 1,1,1,0,0,0, 0,1,0,0, 3,1, 0);
    add( 1,1,1,1,0,0, 0,1,0,0, 3,1, 0);
    add( 2,1,1,0,0,0, 0,1,0,0, 3,2, 0);
    add( 3,1,1,0,0,0, 0,0,0,0, 3,2, 0);
    // Edge on the final HOLD cycle is dropped; next idle edge is accepted.
    add( 1,1,1,1,0,0, 0,0,0,0, 3,2, 1);
    add( 7,1,1,0,0,0, 1,1,0,0, 4,2, 0);
    add( 1,1,1,0,0,0, 1,1,1,0, 4,2, 0);
    add( 3,1,1,0,0,0, 0,1,0,0, 4,2, 0);
    add( 1,1,1,1,0,0, 0,1,0,0, 4,2, 0);
    add( 1,1,1,0,0,0, 0,0,0,0, 4,3, 0);
    add( 1,1,1,1,0,0, 0,0,0,0, 4,3, 1);
    add( 7,1,1,0,0,0, 1,1,0,0, 5,3, 0);
    add( 1,1,1,0,0,0, 1,1,1,0, 5,3, 0);
    add( 4,1,1,0,0,0, 0,1,0,0, 5,3, 0);
    add( 2,1,1,0,0,0, 0,0,0,0, 5,3, 0);
    // run_en low: edge ignored, nothing counted.
    add( 1,1,0,1,0,0, 0,0,0,0, 5,3, 0);
    add( 3,1,0,0,0,0, 0,0,0,0, 5,3, 0);
    // wrusedw=9 leaves 7 free words: dropped.
    add( 1,1,1,1,9,0, 0,0,0,0, 5,3, 0);
    add( 2,1,1,0,9,0, 0,0,0,0, 5,4, 0);
    // fifo_full at the edge: dropped.
    add( 1,1,1,1,0,1, 0,0,0,0, 5,4, 0);
    add( 2,1,1,0,0,0, 0,0,0,0, 5,5, 0);
    // wrusedw=8 leaves exactly 8 words: accepted.
    add( 1,1,1,1,8,0, 0,0,0,0, 5,5, 1);
    add( 7,1,1,0,8,0, 1,1,0,0, 6,5, 0);
    add( 1,1,1,0,8,0, 1,1,1,0, 6,5, 0);
    add( 4,1,1,0,8,0, 0,1,0,0, 6,5, 0);
    add( 2,1,1,0,8,0, 0,0,0,0, 6,5, 0);
    // fifo_full in 3rd window cycle: 2 writes, truncated, no last, HOLD.
    add( 1,1,1,1,0,0, 0,0,0,0, 6,5, 1);
    add( 2,1,1,0,0,0, 1,1,0,0, 7,5, 0);
    add( 1,1,1,0,0,1, 0,1,0,0, 7,5, 0);
    add( 4,1,1,0,0,0, 0,1,0,1, 7,5, 0);
    add( 2,1,1,0,0,0, 0,0,0,1, 7,5, 0);
    // run_en falls mid-window: window still completes.
    add( 1,1,1,1,0,0, 0,0,0,1, 7,5, 1);
    add( 2,1,1,0,0,0, 1,1,0,1, 8,5, 0);
    add( 5,1,0,0,0,0, 1,1,0,1, 8,5, 0);
    add( 1,1,0,0,0,0, 1,1,1,1, 8,5, 0);
    add( 4,1,0,0,0,0, 0,1,0,1, 8,5, 0);
    add( 1,1,1,0,0,0, 0,0,0,1, 8,5, 0);
    // Reset mid-capture: everything clears, next trigger starts fresh.
    add( 1,1,1,1,0,0, 0,0,0,1, 8,5, 1);
    add( 3,1,1,0,0,0, 1,1,0,1, 9,5, 0);
    add( 1,0,1,0,0,0, 1,1,0,1, 9,5, 0);
    add( 4,1,1,0,0,0, 0,0,0,0, 0,0, 0);
    add( 1,1,1,1,0,0, 0,0,0,0, 0,0, 1);
    add( 7,1,1,0,0,0, 1,1,0,0, 1,0, 0);
    add( 1,1,1,0,0,0, 1,1,1,0, 1,0, 0);
    add( 4,1,1,0,0,0, 0,1,0,0, 1,0, 0);
    add( 2,1,1,0,0,0, 0,0,0,0, 1,0, 0);

    do_reset();
    exp_ts = 32'd0;

    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].n; k++) begin
        rst_n     = vt[i].rst_n;
        run_en    = vt[i].run;
        trig_in   = vt[i].trig;
        wrusedw   = vt[i].used;
        fifo_full = vt[i].full;
        @(negedge clk);
        chk("wrreq",    32'(wrreq),     32'(vt[i].wr));
        chk("busy",     32'(busy),      32'(vt[i].bsy));
        chk("win_last", 32'(win_last),  32'(vt[i].last));
        chk("trunc",    32'(truncated), 32'(vt[i].trunc));
        chk("evt_cnt",  32'(evt_cnt),   32'(vt[i].evt));
        chk("drop_cnt", 32'(drop_cnt),  32'(vt[i].drop));
        chk("ts_latch", ts_latch,       ts_want(exp_ts));
        snap = tb_ts;
        @(posedge clk);
        #1;
        if (!vt[i].rst_n)    exp_ts = 32'd0;
        else if (vt[i].acc)  exp_ts = snap;
      end
    end

    // Bounded wait for the end of a window, counting writes on the way.
    trig_in = 1'b1;
    @(posedge clk); #1;
    trig_in = 1'b0;
    nwr  = 0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wrreq) nwr++;
      if (win_last) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wait_last_seen", 32'(seen), 32'd1);
    chk("wait_nwr",       32'(nwr),  32'd8);
    chk("wait_evt",       32'(evt_cnt), 32'd2);
    repeat (8) @(posedge clk);
    #1;
    chk("wait_idle", 32'(busy), 32'd0);

    // Timestamp: trigger in cycle 57 after reset latches 57.
    do_reset();
    rst_n  = 1'b1;
    run_en = 1'b1;
    repeat (57) @(posedge clk);
    #1;
    trig_in = 1'b1;
    @(posedge clk); #1;
    trig_in = 1'b0;
    @(negedge clk);
    chk("ts57",     ts_latch, ts_want(32'd57));
    chk("ts57_evt", 32'(evt_cnt), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    chk("ts57_hold", ts_latch, ts_want(32'd57));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
